// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment font, blank pattern
// and the leading-zero suppression mask helper.
package seg7_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}, indexed by hex value
    localparam logic [SEG_W-1:0] FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Bit i set when digit i and every higher digit are zero; digit 0 never set
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input int unsigned             digits
    );
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                zero_above = zero_above && (value[4*i +: 4] == 4'h0);
                lz_mask[i] = zero_above;
            end
        end
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-low segment pattern lookup.
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous load,
// leading-zero suppression, per-digit decimal points and anti-ghost blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         staging;
    logic [DIGITS-1:0]     staging_dp;
    logic [VW-1:0]         shadow;
    logic [DIGITS-1:0]     shadow_dp;

    logic                  tick;
    logic                  frame_end;
    logic                  in_blank;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  lz_sel;
    logic [DIGITS-1:0]     an_sel;
    logic [MAX_DIGITS-1:0] lz_all;
    logic [SEG_W-1:0]      font_seg_c;
    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;
    logic [DIGITS-1:0]     an_d;

    assign tick      = (presc == PRESC_MAX);
    assign frame_end = tick && (idx == IDX_MAX);

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Staging capture and frame-boundary commit; a load on the boundary bypasses staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging    <= '0;
            staging_dp <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                staging    <= value;
                staging_dp <= dp_in;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (load) begin
                    shadow    <= value;
                    shadow_dp <= dp_in;
                end else if (pending) begin
                    shadow    <= staging;
                    shadow_dp <= staging_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign lz_all = lz_mask((4*MAX_DIGITS)'(shadow), DIGITS);

    // Select the active digit's nibble, decimal point, suppression bit and anode
    always_comb begin
        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        lz_sel  = 1'b0;
        an_sel  = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib_sel   = shadow[4*i +: 4];
                dp_sel    = shadow_dp[i];
                lz_sel    = lz_all[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    seg7_font u_font (
        .nibble (nib_sel),
        .seg_c  (font_seg_c)
    );

    assign in_blank = (32'(presc) < BLANK_CYCLES);

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!in_blank) begin
            seg_d = (blank_lz && lz_sel) ? SEG_OFF : font_seg_c;
            dp_d  = ~dp_sel;
            an_d  = an_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_d;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2)
// against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int CDIV   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * CDIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          n;
    logic [15:0] m_stg, m_shadow;
    logic [3:0]  m_stg_dp, m_dp;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001; 4'h1: return 7'b1001111;
            4'h2: return 7'b0010010; 4'h3: return 7'b0000110;
            4'h4: return 7'b1001100; 4'h5: return 7'b0100100;
            4'h6: return 7'b0100000; 4'h7: return 7'b0001111;
            4'h8: return 7'b0000000; 4'h9: return 7'b0000100;
            4'hA: return 7'b0001000; 4'hB: return 7'b1100000;
            4'hC: return 7'b0110001; 4'hD: return 7'b1000010;
            4'hE: return 7'b0110000; default: return 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; m_stg = '0; m_shadow = '0; m_stg_dp = '0; m_dp = '0; m_pend = 1'b0;
    endtask

    // Expected outputs come from the slot position implied by the cycle count;
    // then the model takes the edge and the DUT is clocked, ending on a negedge.
    task automatic step();
        int p, d;
        logic [15:0] upper;
        p = n % CDIV;
        d = (n / CDIV) % DIGITS;
        if (p < BLANK) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            upper   = m_shadow >> (4 * d);
            exp_an  = ~(4'b0001 << d);
            exp_seg = (blank_lz && d > 0 && upper == 16'h0) ? 7'h7F : font_ref(upper[3:0]);
            exp_dp  = ~m_dp[d];
        end
        if ((n % FRAME) == FRAME - 1 && (m_pend || load)) begin
            m_shadow = load ? value : m_stg;
            m_dp     = load ? dp_in : m_stg_dp;
            m_pend   = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin m_stg = value; m_stg_dp = dp_in; end
        n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({an, seg, dp, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got an=%b seg=%b dp=%b pending=%b, expected an=1111 seg=1111111 dp=1 pending=0", an, seg, dp, pending);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({an, seg} !== {4'b1110, 7'b0000001}) begin
            errors++;
            $display("FAIL reset_slot0: got an=%b seg=%b, expected an=1110 seg=0000001", an, seg);
        end
        repeat (FRAME - 3) begin
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL reset_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
    endtask

    task automatic test_load_scan();
        repeat (5) step();
        value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: got pending=%b, expected 1", pending);
        end
        repeat (2 * FRAME) begin
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL load_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        vals[0] = 16'h0050; vals[1] = 16'h0000;
        blank_lz = 1'b1;
        for (int k = 0; k < 2; k++) begin
            value = vals[k]; dp_in = 4'b1000; load = 1'b1;
            step();
            load = 1'b0;
            repeat (2 * FRAME) begin
                step();
                checks++;
                if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                    errors++;
                    $display("FAIL lz_scan v=%h n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", vals[k], n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_anti_tear();
        while ((n % FRAME) != 10) step();
        value = 16'hAAAA; dp_in = 4'b0001; load = 1'b1;
        step();
        value = 16'hBEEF; dp_in = 4'b0000;
        step();
        load = 1'b0;
        repeat (2 * FRAME) begin
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL tear_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
    endtask

    task automatic test_boundary();
        while ((n % FRAME) != FRAME - 1) step();
        value = 16'hC0DE; dp_in = 4'b0010; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL boundary_pending: got pending=%b, expected 0", pending);
        end
        repeat (FRAME + 4) begin
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL boundary_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            load     = ($urandom_range(0, 19) == 0) || ((n % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0);
            value    = 16'($urandom);
            if ($urandom_range(0, 2) == 0) value = value >> (4 * $urandom_range(1, 3));
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL random_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
        load = 1'b0; blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid();
        while ((n % FRAME) != 3 * CDIV - 4) step();
        value = 16'h9876; dp_in = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_pending_before: got pending=%b, expected 1", pending);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({an, seg, dp, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got an=%b seg=%b dp=%b pending=%b, expected an=1111 seg=1111111 dp=1 pending=0", an, seg, dp, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 4) begin
            step();
            checks++;
            if ({an, seg, dp, pending} !== {exp_an, exp_seg, exp_dp, m_pend}) begin
                errors++;
                $display("FAIL mid_reset_scan n=%0d: got an=%b seg=%b dp=%b pend=%b, expected an=%b seg=%b dp=%b pend=%b", n, an, seg, dp, pending, exp_an, exp_seg, exp_dp, m_pend);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_scan();
        test_lz();
        test_anti_tear();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of DIGITS common-anode 7-segment displays. It holds a hex value of DIGITS nibbles and scans one digit per refresh slot, driving active-low segments and active-low anodes. Features beyond a single-digit decoder:
- a frame-synchronous load so the display never tears;
- optional leading-zero suppression;
- per-digit decimal points;
- an anti-ghosting blank interval.

It sits between the register/datapath logic and the board display pins.

## Interface
- DIGITS, 4: number of digits; legal 1..8.
- CLK_DIV, 1000: clock cycles per digit slot; legal ≥ 2.
- BLANK_CYCLES, 2: cycles at slot start with all anodes off; legal 0..CLK_DIV-1.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  capture value/dp_in this cycle.
- value  in  4*DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros (level, sampled every cycle).
- seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  anode enables, active-low, at most one low.
- pending  out  1  staged value not yet displayed.

## Operation
- **Prescaler** presc: counts 0..CLK_DIV-1 and wraps. tick = (presc == CLK_DIV-1).
- **Digit index** idx: advances on tick and wraps DIGITS-1 → 0. The wrap edge is the frame boundary.
- **Load**: load=1 captures value/dp_in into the staging registers and sets pending=1. Repeated loads before commit overwrite the staging registers; last wins.
- **Commit** (frame boundary with pending=1): shadow ← staging, pending ← 0.
- **Load on the commit cycle**: the incoming value/dp_in are committed directly (bypass) and pending stays 0.
- The displayed content is the shadow only.
- **Font**, hex → seg:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- **Leading-zero suppression** (blank_lz=1):
  - Digit i is blank (seg=1111111) iff it and all higher digits are 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit still follows shadow dp.
- **Slot output**:
  - If presc < BLANK_CYCLES: an = all 1, seg = 1111111, dp = 1.
  - Otherwise: an[idx] = 0, seg = font/blank of shadow digit idx, dp = ~shadow_dp[idx].
- **Reset values**:
  - presc = 0, idx = 0, staging = 0, shadow = 0, pending = 0.
  - seg = 1111111, dp = 1, an = all 1.

## Timing
- seg, dp and an are registered. They reflect the (presc, idx, shadow) state of the previous cycle, giving 1-cycle latency.
- Digit slot length is exactly CLK_DIV cycles. Frame length is DIGITS*CLK_DIV cycles.
- pending rises the cycle after load. It falls the cycle after the commit edge.
- New content first appears on digit 0 at the start of the frame following the commit, after BLANK_CYCLES+1 cycles.
- DIGITS=1: every tick is a frame boundary.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, without a clock edge. A staged, uncommitted value is discarded.
- Widths: presc is max(1,$clog2(CLK_DIV)) bits; idx is max(1,$clog2(DIGITS)) bits. Neither counter ever exceeds its legal range.

## Structure
- **Package seg7_pkg**:
  - SEG_OFF = 7'b1111111.
  - The 16-entry font constant array.
  - A function lz_mask(value) returning the suppression mask.
- **Sub-module seg7_font**: combinational 4-bit → 7-bit lookup using the package font, instantiated once on the selected digit.
- The top module holds the prescaler, idx, staging/shadow registers, commit logic and output registers.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
1. **Reset**: hold rst_n=0 → seg=1111111, dp=1, an=1111, pending=0. Release with blank_lz=0 → the digit 0 slot shows an=1110, seg=0000001.
2. **Load and scan**: load 16'h1234, dp_in=0100.
   - pending=1 until the wrap.
   - Next frame: slot 0 shows an=1110, seg=1001100; slot 1 shows 0000110; slot 2 shows 0010010 with dp=0; slot 3 shows an=0111, seg=1001111.
   - Each slot's first 2 cycles (+1 latency) have an=1111.
3. **Leading-zero suppression**: load 16'h0050 with blank_lz=1.
   - Digits 3 and 2 show seg=1111111; digit 1 shows 0100100; digit 0 shows 0000001.
   - With value 0, only digit 0 shows 0000001.
4. **Anti-tearing**: loads of 16'hAAAA then 16'hBEEF mid-frame → the current frame is unchanged and pending=1. The next frame shows BEEF (1100000, 0110000, 0110000, 0111000).
5. **Load on the boundary**: load 16'hC0DE on the wrap tick cycle → pending stays 0 and the next frame shows C0DE.
6. **Reset mid-frame**: rst_n=0 mid-slot with a value pending → outputs go to reset values asynchronously. After release, all digits show 0 and pending=0.
